// File: rtl/tdc_hw_accum.sv
// Batch statistics over TDC Hamming-weight codes: sum, mean, min and max of
// 2^LOG2_SAMPLES strobed samples, with a registered byte-wide readout mux.
module tdc_hw_accum #(
    parameter int HW_W         = 7,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         start,
    input  logic                         sample_stb,
    input  logic [HW_W-1:0]              hw,
    input  logic [1:0]                   out_sel,
    output logic                         busy,
    output logic                         done,
    output logic [HW_W+LOG2_SAMPLES-1:0] sum,
    output logic [HW_W-1:0]              mean,
    output logic [HW_W-1:0]              hw_min,
    output logic [HW_W-1:0]              hw_max,
    output logic [7:0]                   dout
);
    localparam int SUM_W = HW_W + LOG2_SAMPLES;

    // Handshake: sample_stb is a single-cycle qualifier for hw; it is only
    // consumed in ACCUM and only when start is not asserted in the same cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic                      init_work, take_sample, last_sample;
    logic [SUM_W-1:0]          acc, acc_nxt;
    logic [HW_W-1:0]           wmin, wmax, wmin_nxt, wmax_nxt;
    logic [LOG2_SAMPLES-1:0]   cnt;
    logic [7:0]                dout_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        init_work   = 1'b0;
        take_sample = 1'b0;
        last_sample = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = ACCUM;
                        init_work = 1'b1;
                    end
                end
                ACCUM: begin
                    // A restart outranks a coincident strobe.
                    if (start) begin
                        init_work = 1'b1;
                    end else if (sample_stb) begin
                        take_sample = 1'b1;
                        if (cnt == '1) begin
                            last_sample = 1'b1;
                            state_nxt   = DONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy     = (state == ACCUM);
    assign done     = (state == DONE);
    assign acc_nxt  = acc + SUM_W'(hw);
    assign wmin_nxt = (hw < wmin) ? hw : wmin;
    assign wmax_nxt = (hw > wmax) ? hw : wmax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            wmin <= '0;
            wmax <= '0;
            cnt  <= '0;
        end else if (init_work) begin
            acc  <= '0;
            wmin <= '1;
            wmax <= '0;
            cnt  <= '0;
        end else if (take_sample) begin
            acc  <= acc_nxt;
            wmin <= wmin_nxt;
            wmax <= wmax_nxt;
            cnt  <= cnt + 1'b1;
        end
    end

    // Published results only move when the final sample of a batch lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum    <= '0;
            mean   <= '0;
            hw_min <= '0;
            hw_max <= '0;
        end else if (last_sample) begin
            sum    <= acc_nxt;
            mean   <= acc_nxt[SUM_W-1:LOG2_SAMPLES];
            hw_min <= wmin_nxt;
            hw_max <= wmax_nxt;
        end
    end

    always_comb begin
        dout_nxt = '0;
        case (out_sel)
            2'd0:    dout_nxt = 8'(mean);
            2'd1:    dout_nxt = 8'(hw_min);
            2'd2:    dout_nxt = 8'(hw_max);
            default: dout_nxt = 8'(sum);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= '0;
        else        dout <= dout_nxt;
    end

endmodule
